// File: rtl/pte_bu.sv
// Page-table walker bus unit: turns one walker read/write pulse into a single
// 64-bit AHB SINGLE transfer, owning the bus through the bus_req/bus_ack handshake.
module pte_bu #(
  parameter logic [3:0]  HPROT   = 4'b0011,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  // Walker side
  input  logic        pte_rd_req,
  input  logic        pte_wr_req,
  input  logic [63:0] pte_addr,
  input  logic [63:0] pte_wdata,
  output logic        pte_busy,
  output logic        pte_ack,
  output logic        pte_err,
  output logic [63:0] pte_rdata,
  // Arbiter handshake
  output logic        bus_req,
  input  logic        bus_ack,
  // AHB master port
  output logic [63:0] haddr,
  output logic        hwrite,
  output logic [3:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [1:0]  htrans,
  output logic        hmastlock,
  output logic [63:0] hwdata,
  input  logic        hready,
  input  logic        hresp,
  input  logic        hreset_n,
  input  logic [63:0] hrdata
);

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  // Stall counter must be able to hold TIMEOUT; keep one bit when disabled.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRel,
    StReq,
    StAddr,
    StData,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic              dir_q, dir_d;        // 1: write
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [63:0]       haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [63:0]       hwdata_q, hwdata_d;
  logic              bus_req_q, bus_req_d;
  logic              pte_ack_q, pte_ack_d;
  logic              pte_err_q, pte_err_d;
  logic [63:0]       pte_rdata_q, pte_rdata_d;
  logic              done_err;
  logic              bad_req;
  logic              tmo_hit;

  // A request with both pulses or a non-doubleword address never touches the bus.
  assign bad_req = (pte_rd_req && pte_wr_req) || (pte_addr[2:0] != 3'b000);

  // This stall cycle would be the TIMEOUT-th one.
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  // Next-state logic, request latching and read-data capture.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    haddr_d     = haddr_q;
    hwdata_d    = hwdata_q;
    pte_rdata_d = pte_rdata_q;
    done_err    = 1'b0;

    case (state_q)
      StIdle: begin
        if (pte_rd_req || pte_wr_req) begin
          haddr_d = pte_addr;
          dir_d   = pte_wr_req;
          if (pte_wr_req) begin
            hwdata_d = pte_wdata;
          end
          if (bad_req) begin
            state_d  = StDone;
            done_err = 1'b1;
          end else if (bus_ack) begin
            // Grant still up from the previous owner cycle; let it fall first.
            state_d = StWaitRel;
          end else begin
            state_d = StReq;
          end
        end
      end

      StWaitRel: begin
        if (!bus_ack) begin
          state_d = StReq;
        end
      end

      StReq: begin
        if (!hreset_n) begin
          state_d  = StDone;
          done_err = 1'b1;
        end else if (bus_ack) begin
          state_d = StAddr;
          cnt_d   = '0;
        end
      end

      StAddr: begin
        if (!hreset_n || !bus_ack) begin
          state_d  = StDone;
          done_err = 1'b1;
        end else if (hready) begin
          state_d = StData;
        end else if (tmo_hit) begin
          state_d  = StDone;
          done_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StData: begin
        if (!hreset_n || !bus_ack) begin
          state_d  = StDone;
          done_err = 1'b1;
        end else if (hready) begin
          // First cycle of a two-cycle error response has hready low and is
          // simply waited out; the error is taken here.
          state_d  = StDone;
          done_err = hresp;
          if (!dir_q && !hresp) begin
            pte_rdata_d = hrdata;
          end
        end else if (tmo_hit) begin
          state_d  = StDone;
          done_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered outputs are computed from the state being entered.
  always_comb begin
    htrans_d  = (state_d == StAddr) ? HtransNonseq : HtransIdle;
    hwrite_d  = (state_d == StAddr) && dir_d;
    bus_req_d = (state_d == StReq) || (state_d == StAddr) || (state_d == StData);
    pte_ack_d = (state_d == StDone);
    pte_err_d = (state_d == StDone) && done_err;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      htrans_q    <= HtransIdle;
      hwdata_q    <= '0;
      bus_req_q   <= 1'b0;
      pte_ack_q   <= 1'b0;
      pte_err_q   <= 1'b0;
      pte_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      htrans_q    <= htrans_d;
      hwdata_q    <= hwdata_d;
      bus_req_q   <= bus_req_d;
      pte_ack_q   <= pte_ack_d;
      pte_err_q   <= pte_err_d;
      pte_rdata_q <= pte_rdata_d;
    end
  end

  assign pte_busy  = (state_q != StIdle);
  assign pte_ack   = pte_ack_q;
  assign pte_err   = pte_err_q;
  assign pte_rdata = pte_rdata_q;
  assign bus_req   = bus_req_q;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign htrans    = htrans_q;
  assign hwdata    = hwdata_q;
  assign hsize     = 4'b0011;
  assign hburst    = 3'b000;
  assign hprot     = HPROT;
  assign hmastlock = 1'b0;

  // Protocol invariants of the walker and bus sides.
  a_err_with_ack: assert property (@(posedge clk) disable iff (rst) pte_err |-> pte_ack);
  a_ack_single: assert property (@(posedge clk) disable iff (rst) pte_ack |=> !pte_ack);
  a_hwrite_addr: assert property (@(posedge clk) disable iff (rst)
                                  hwrite |-> (htrans == HtransNonseq));

endmodule

// File: tb/tb_pte_bu.sv
// Randomized bench for pte_bu: reactive arbiter and AHB slave models driven from
// per-transaction knobs, with ack timing, error and read data predicted from
// the transaction parameters.
module tb_pte_bu;

  localparam int TMO = 8;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic        clk;
  logic        rst;
  logic        pte_rd_req, pte_wr_req;
  logic [63:0] pte_addr, pte_wdata;
  logic        pte_busy, pte_ack, pte_err;
  logic [63:0] pte_rdata;
  logic        bus_req, bus_ack;
  logic [63:0] haddr;
  logic        hwrite;
  logic [3:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [63:0] hwdata;
  logic        hready, hresp, hreset_n;
  logic [63:0] hrdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pte_bu #(
    .HPROT   (4'b0011),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pte_rd_req (pte_rd_req),
    .pte_wr_req (pte_wr_req),
    .pte_addr   (pte_addr),
    .pte_wdata  (pte_wdata),
    .pte_busy   (pte_busy),
    .pte_ack    (pte_ack),
    .pte_err    (pte_err),
    .pte_rdata  (pte_rdata),
    .bus_req    (bus_req),
    .bus_ack    (bus_ack),
    .haddr      (haddr),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hburst     (hburst),
    .hprot      (hprot),
    .htrans     (htrans),
    .hmastlock  (hmastlock),
    .hwdata     (hwdata),
    .hready     (hready),
    .hresp      (hresp),
    .hreset_n   (hreset_n),
    .hrdata     (hrdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Arbiter model knobs/state.
  int arb_g, arb_lag, arb_hi, arb_lag_cnt;
  // Slave model knobs/state.
  int s_a, s_d, s_acnt, s_dcnt;
  bit s_data, s_err, in_dphase;
  logic [63:0] s_rdv;
  // Reference: last error-free read data.
  logic [63:0] exp_rdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; at the falling edge update arbiter and slave inputs.
  task automatic tick();
    @(negedge clk);
    if (bus_req) begin
      if (arb_hi >= arb_g) bus_ack = 1'b1;
      arb_hi++;
      arb_lag_cnt = arb_lag;
    end else begin
      arb_hi = 0;
      if (bus_ack && arb_lag_cnt > 0) arb_lag_cnt--;
      else bus_ack = 1'b0;
    end
    in_dphase = s_data;
    hready    = 1'b1;
    hresp     = 1'b0;
    hrdata    = {$urandom, $urandom};
    if (s_data) begin
      hready = (s_dcnt >= s_d);
      hresp  = s_err && (s_dcnt + 1 >= s_d);
      if (hready) begin
        hrdata = s_rdv;
        s_data = 1'b0;
      end else begin
        s_dcnt++;
      end
    end else if (htrans == NONSEQ) begin
      hready = (s_acnt >= s_a);
      if (hready) begin
        s_data = 1'b1;
        s_dcnt = 0;
      end else begin
        s_acnt++;
      end
    end
  endtask

  task automatic do_txn(input bit rd, input bit wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdv,
                        input int g, input int a, input int d, input bit rerr,
                        input bit want_abort, input int lag);
    int  extra, cycles, ack_at, abort_at, nonseq, exp_ns;
    bit  bad, timed, exp_err, req_seen, got_ack;
    tick();
    check_eq("idle_ack", pte_ack, 1'b0);
    check_eq("idle_busy", pte_busy, 1'b0);
    arb_g = g; arb_lag = lag;
    s_a = a; s_d = d; s_err = rerr; s_rdv = rdv; s_acnt = 0; s_data = 1'b0;
    extra = bus_ack ? 1 + arb_lag_cnt : 0;
    pte_rd_req = rd; pte_wr_req = wr; pte_addr = addr; pte_wdata = wdata;
    hreset_n = ($urandom_range(0, 3) != 0);  // ignored while idle
    bad = (rd && wr) || (addr[2:0] != 3'b000);
    timed = 1'b0; exp_err = 1'b1; abort_at = 0;
    if (bad) begin
      ack_at = 1;
    end else begin
      if (a >= TMO) begin
        cycles = TMO; timed = 1'b1;
      end else if (a + d >= TMO) begin
        cycles = TMO + 1; timed = 1'b1;
      end else begin
        cycles = a + d + 2;
      end
      ack_at  = extra + 2 + g + cycles;
      exp_err = timed || rerr;
      if (want_abort && !timed) begin
        abort_at = $urandom_range(extra + 1, ack_at - 1);
        ack_at   = abort_at + 1;
        exp_err  = 1'b1;
      end
    end
    if (!exp_err && rd) exp_rdata = rdv;
    exp_ns = (timed && a >= TMO) ? TMO : a + 1;

    nonseq = 0; req_seen = 1'b0; got_ack = 1'b0;
    for (int k = 1; k <= ack_at + 3 && !got_ack; k++) begin
      tick();
      pte_rd_req = 1'b0; pte_wr_req = 1'b0;
      hreset_n = (k != abort_at);
      if (bus_req) req_seen = 1'b1;
      if (htrans == NONSEQ) begin
        nonseq++;
        check_eq("nonseq_haddr", haddr, addr);
        check_eq("nonseq_hwrite", hwrite, wr);
        check_eq("nonseq_granted", bus_ack, 1'b1);
      end
      if (in_dphase && wr) check_eq("data_hwdata", hwdata, wdata);
      if (pte_ack) begin
        got_ack = 1'b1;
        check_eq("ack_cycle", k, ack_at);
        check_eq("ack_err", pte_err, exp_err);
        check_eq("ack_rdata", pte_rdata, exp_rdata);
        check_eq("ack_bus_req", bus_req, 1'b0);
        check_eq("ack_htrans", htrans, 2'b00);
        if (bad) begin
          check_eq("bad_bus_req", req_seen, 1'b0);
          check_eq("bad_nonseq", nonseq, 0);
        end else if (abort_at == 0) begin
          check_eq("nonseq_count", nonseq, exp_ns);
        end
      end else begin
        check_eq("busy", pte_busy, 1'b1);
      end
    end
    check_eq("ack_seen", got_ack, 1'b1);
    hreset_n = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    pte_rd_req = 1'b0; pte_wr_req = 1'b0; pte_addr = '0; pte_wdata = '0;
    bus_ack = 1'b0; hready = 1'b1; hresp = 1'b0; hreset_n = 1'b1; hrdata = '0;
    arb_g = 0; arb_lag = 0; arb_hi = 0; arb_lag_cnt = 0;
    s_a = 0; s_d = 0; s_acnt = 0; s_dcnt = 0; s_data = 1'b0; s_err = 1'b0;
    in_dphase = 1'b0; s_rdv = '0; exp_rdata = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_bus_req", bus_req, 1'b0);
    check_eq("rst_ack", pte_ack, 1'b0);
    check_eq("rst_err", pte_err, 1'b0);
    check_eq("rst_busy", pte_busy, 1'b0);
    check_eq("rst_htrans", htrans, 2'b00);
    check_eq("rst_haddr", haddr, 64'h0);
    check_eq("rst_hwdata", hwdata, 64'h0);
    check_eq("rst_rdata", pte_rdata, 64'h0);
    check_eq("const_hsize", hsize, 4'b0011);
    check_eq("const_hburst", hburst, 3'b000);
    check_eq("const_hprot", hprot, 4'b0011);
    check_eq("const_hmastlock", hmastlock, 1'b0);
    rst = 1'b0;

    // Directed cases.
    do_txn(1, 0, 64'h8000_1000, 64'h0, 64'h0000_0000_2000_00CF, 0, 0, 0, 0, 0, 0);
    do_txn(0, 1, 64'h8000_2008, 64'hC0, 64'h0, 0, 0, 3, 0, 0, 0);
    do_txn(1, 0, 64'h8000_0004, 64'h0, 64'h1234, 0, 0, 0, 0, 0, 0);
    do_txn(1, 1, 64'h8000_3000, 64'h55, 64'h1234, 0, 0, 0, 0, 0, 0);
    do_txn(1, 0, 64'h8000_3008, 64'h0, 64'hDEAD_BEEF, 0, 0, 1, 1, 0, 0);
    do_txn(1, 0, 64'h8000_4000, 64'h0, 64'h77, 0, 20, 0, 0, 0, 0);
    do_txn(0, 1, 64'h8000_4008, 64'h99, 64'h0, 1, 2, 20, 0, 0, 0);
    do_txn(1, 0, 64'h8000_5000, 64'h0, 64'hABCD, 5, 0, 0, 0, 0, 2);
    do_txn(1, 0, 64'h8000_5008, 64'h0, 64'h5678, 0, 0, 0, 0, 0, 0);
    do_txn(0, 1, 64'h8000_6000, 64'h11, 64'h0, 0, 1, 1, 0, 1, 0);

    // Synchronous reset during the data phase.
    repeat (5) tick();
    arb_g = 0; arb_lag = 0;
    s_a = 0; s_d = 5; s_err = 1'b0; s_acnt = 0; s_data = 1'b0; s_rdv = 64'h4242;
    pte_rd_req = 1'b1; pte_addr = 64'h8000_7000;
    tick();
    pte_rd_req = 1'b0;
    tick();
    tick();
    check_eq("pre_rst_busy", pte_busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rdata = '0;
    check_eq("midrst_bus_req", bus_req, 1'b0);
    check_eq("midrst_ack", pte_ack, 1'b0);
    check_eq("midrst_err", pte_err, 1'b0);
    check_eq("midrst_busy", pte_busy, 1'b0);
    check_eq("midrst_htrans", htrans, 2'b00);
    check_eq("midrst_hwrite", hwrite, 1'b0);
    check_eq("midrst_haddr", haddr, 64'h0);
    check_eq("midrst_hwdata", hwdata, 64'h0);
    check_eq("midrst_rdata", pte_rdata, 64'h0);
    s_data = 1'b0;
    repeat (3) begin
      tick();
      check_eq("midrst_no_ack", pte_ack, 1'b0);
    end

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      int          sel, g, a, d, lag;
      bit          rd, wr, rerr, abrt;
      logic [63:0] addr;
      sel  = $urandom_range(0, 9);
      rd   = (sel <= 4);
      wr   = (sel == 0) || (sel >= 5);
      addr = {$urandom, $urandom};
      addr[2:0] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      g    = $urandom_range(0, 3);
      a    = $urandom_range(0, 2);
      d    = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) a = $urandom_range(6, 12);
      rerr = (d >= 1) && ($urandom_range(0, 5) == 0);
      abrt = (a + d < 6) && ($urandom_range(0, 6) == 0);
      lag  = $urandom_range(0, 3);
      repeat ($urandom_range(0, 1)) tick();
      do_txn(rd, wr, addr, {$urandom, $urandom}, {$urandom, $urandom}, g, a, d, rerr, abrt,
             lag);
    end

    tick();
    check_eq("final_ack", pte_ack, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
